dmem_mmio: RTL and testbench

Data-side memory subsystem for the pipelined RV32I core. It consumes the MEM-stage outputs of the core (`ALU_out` as address, `data_out`, `mem_w`) and returns `data_in` in the same cycle. It contains word-addressed data RAM plus a small memory-mapped peripheral region:
- free-running cycle counter
- 8-bit LED register
- UART transmitter driven by a framing state machine

---
 rtl/dmem_mmio.sv | 130 +++++++++++++
 tb/tb_dmem_mmio.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory for the RV32I core: word RAM plus a small MMIO block
// (cycle counter, LED register, UART transmitter).
module dmem_mmio #(
  parameter int DEPTH_WORDS = 1024,
  parameter int CLK_DIV     = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_w,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic [7:0]  led
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = $clog2(CLK_DIV);

  localparam logic [31:0] UART_DATA  = 32'hFFFF_0000;
  localparam logic [31:0] UART_STAT  = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE_ADDR = 32'hFFFF_0008;
  localparam logic [31:0] LED_ADDR   = 32'hFFFF_000C;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  uart_state_t   state;
  logic [BW-1:0] bcnt;
  logic [2:0]    bidx;
  logic [7:0]    shift;
  logic [31:0]   cycle;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic          busy;
  logic          baud_done;
  logic          frame_end;
  logic          uart_accept;

  assign ram_hit   = (addr[31:AW+2] == '0);
  assign ram_idx   = addr[AW+1:2];
  assign busy      = (state != IDLE);
  assign baud_done = (bcnt == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_done;
  // A write landing on the last stop-bit edge starts the next frame with no gap.
  assign uart_accept = mem_w && (addr == UART_DATA) && (!busy || frame_end);

  always_ff @(posedge clk) begin
    if (mem_w && ram_hit) mem[ram_idx] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = mem[ram_idx];
    end else begin
      case (addr)
        UART_STAT:  rdata = {31'b0, busy};
        CYCLE_ADDR: rdata = cycle;
        LED_ADDR:   rdata = {24'b0, led};
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle <= '0;
      led   <= '0;
    end else begin
      cycle <= (mem_w && addr == CYCLE_ADDR) ? wdata : cycle + 32'd1;
      if (mem_w && addr == LED_ADDR) led <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      bidx    <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else if (uart_accept) begin
      state   <= START;
      bcnt    <= '0;
      bidx    <= '0;
      shift   <= wdata[7:0];
      uart_tx <= 1'b0;
    end else begin
      case (state)
        IDLE: uart_tx <= 1'b1;
        START: begin
          if (baud_done) begin
            state   <= DATA;
            bcnt    <= '0;
            bidx    <= '0;
            uart_tx <= shift[0];
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            bcnt <= '0;
            if (bidx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bidx    <= bidx + 3'd1;
              uart_tx <= shift[bidx + 3'd1];
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            state <= IDLE;
            bcnt  <= '0;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: a frame-level reference model predicts
// rdata, uart_tx and led each cycle; a monitor process compares.
module tb_dmem_mmio;
  localparam int DW = 16;
  localparam int C  = 4;

  localparam logic [31:0] UART_DATA  = 32'hFFFF_0000;
  localparam logic [31:0] UART_STAT  = 32'hFFFF_0004;
  localparam logic [31:0] CYCLE_ADDR = 32'hFFFF_0008;
  localparam logic [31:0] LED_ADDR   = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_w = 1'b0;
  logic [31:0] rdata;
  logic        uart_tx;
  logic [7:0]  led;

  always #5 clk = ~clk;

  dmem_mmio #(.DEPTH_WORDS(DW), .CLK_DIV(C)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_w(mem_w),
    .rdata(rdata), .uart_tx(uart_tx), .led(led)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] exp_rdata;
    logic        exp_tx;
    logic [7:0]  exp_led;
  } item_t;

  item_t sbq[$];
  int errors = 0;
  int checks = 0;

  // Model state, always describing the design after n edges since reset release.
  logic [31:0] m_ram [DW];
  logic [7:0]  m_led = '0;
  logic [31:0] m_cyc = '0;
  int          n = 0;
  int          f_start = -1;
  logic [7:0]  f_byte = '0;

  function automatic bit m_busy(int t);
    return (f_start >= 0) && (t >= f_start) && (t < f_start + 10*C);
  endfunction

  function automatic logic m_tx(int t);
    int i;
    if (!m_busy(t)) return 1'b1;
    i = (t - f_start) / C;
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return f_byte[i-1];
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (a < 32'(DW*4)) return m_ram[int'(a >> 2)];
    case (a)
      UART_STAT:  return {31'b0, m_busy(n)};
      CYCLE_ADDR: return m_cyc;
      LED_ADDR:   return {24'b0, m_led};
      default:    return 32'h0;
    endcase
  endfunction

  task automatic step(input string nm, input logic [31:0] a, input logic [31:0] w,
                      input logic we, input logic r);
    item_t it;
    @(negedge clk);
    rst = r; addr = a; wdata = w; mem_w = we;
    if (r) begin
      m_led = '0; m_cyc = '0; n = 0; f_start = -1;
    end
    it.name = nm; it.a = a;
    it.exp_rdata = m_read(a);
    it.exp_tx = m_tx(n);
    it.exp_led = m_led;
    sbq.push_back(it);
    if (!r) begin
      if (we) begin
        if (a < 32'(DW*4)) m_ram[int'(a >> 2)] = w;
        if (a == UART_DATA && (!m_busy(n) || n == f_start + 10*C - 1)) begin
          f_start = n + 1;
          f_byte  = w[7:0];
        end
        if (a == LED_ADDR) m_led = w[7:0];
      end
      m_cyc = (we && a == CYCLE_ADDR) ? w : m_cyc + 32'd1;
      n++;
    end
  endtask

  task automatic idle(input string nm, input int cnt);
    for (int i = 0; i < cnt; i++) step(nm, UART_STAT, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        checks++;
        if (rdata !== it.exp_rdata) begin
          errors++;
          $display("FAIL %s rdata addr=%h got=%h exp=%h t=%0t", it.name, it.a, rdata, it.exp_rdata, $time);
        end
        checks++;
        if (uart_tx !== it.exp_tx) begin
          errors++;
          $display("FAIL %s uart_tx got=%b exp=%b t=%0t", it.name, uart_tx, it.exp_tx, $time);
        end
        checks++;
        if (led !== it.exp_led) begin
          errors++;
          $display("FAIL %s led got=%h exp=%h t=%0t", it.name, led, it.exp_led, $time);
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] a;
    int sel;
    step("rst_cyc",  CYCLE_ADDR, 32'h0, 1'b0, 1'b1);
    step("rst_stat", UART_STAT,  32'h0, 1'b0, 1'b1);
    step("rst_led",  LED_ADDR,   32'h0, 1'b0, 1'b1);
    step("rel_cyc",  CYCLE_ADDR, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("cyc_count", CYCLE_ADDR, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < DW; i++) step("ram_fill", 32'(i*4), $urandom, 1'b1, 1'b0);

    step("ram_wr",   32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step("ram_rd",   32'h10, 32'h0, 1'b0, 1'b0);
    step("ram_rd13", 32'h13, 32'h0, 1'b0, 1'b0);
    step("ram_rdw",  32'h10, 32'h1234_5678, 1'b1, 1'b0);
    step("ram_new",  32'h10, 32'h0, 1'b0, 1'b0);

    step("led_wr", LED_ADDR, 32'hFFFF_FFA5, 1'b1, 1'b0);
    step("led_rd", LED_ADDR, 32'h0, 1'b0, 1'b0);

    step("uart55_wr", UART_DATA, 32'h55, 1'b1, 1'b0);
    step("uart_rd0",  UART_DATA, 32'h0, 1'b0, 1'b0);
    idle("uart55", 45);

    step("uart41_wr", UART_DATA, 32'h41, 1'b1, 1'b0);
    idle("uart41", 1);
    step("uart42_drop", UART_DATA, 32'h42, 1'b1, 1'b0);
    for (int k = 0; k < 100 && n < f_start + 10*C - 1; k++) idle("uart41", 1);
    step("uart43_b2b", UART_DATA, 32'h43, 1'b1, 1'b0);
    idle("uart43", 42);

    step("stat_wr", UART_STAT, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step("cyc_ld",  CYCLE_ADDR, 32'hFFFF_FFFE, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("cyc_wrap", CYCLE_ADDR, 32'h0, 1'b0, 1'b0);

    step("unm_wr_hi",  32'h8000_0000, 32'h1234, 1'b1, 1'b0);
    step("unm_wr_end", 32'(DW*4), 32'h1234, 1'b1, 1'b0);
    step("unm_rd_hi",  32'h8000_0000, 32'h0, 1'b0, 1'b0);
    step("unm_rd_end", 32'(DW*4), 32'h0, 1'b0, 1'b0);
    step("unm_rd_mm",  32'hFFFF_0010, 32'h0, 1'b0, 1'b0);
    step("unm_ram0",   32'h0, 32'h0, 1'b0, 1'b0);
    step("unm_led",    LED_ADDR, 32'h0, 1'b0, 1'b0);

    step("mid_wr", UART_DATA, 32'h3C, 1'b1, 1'b0);
    idle("mid_frame", 10);
    step("mid_rst_stat", UART_STAT, 32'h0, 1'b0, 1'b1);
    step("mid_rst_cyc",  CYCLE_ADDR, 32'h0, 1'b0, 1'b1);
    step("mid_rel_ram",  32'h10, 32'h0, 1'b0, 1'b0);
    step("mid_rel_led",  LED_ADDR, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0, 1:    a = $urandom_range(0, DW*4 - 1);
        2:       a = UART_DATA;
        3:       a = UART_STAT;
        4:       a = CYCLE_ADDR;
        5:       a = LED_ADDR;
        6:       a = 32'(DW*4) + $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      step("rand", a, $urandom, ($urandom_range(0, 3) == 0), 1'b0);
    end

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #4;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
